// File: rtl/cpu_types_pkg.sv
// Shared MIPS types: word/register types, opcode and funct encodings, ALU ops and the
// decoded control bundle produced by mips_decoder.
package cpu_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;

  typedef enum logic [5:0] {
    OpRtype = 6'b000000,
    OpJ     = 6'b000010,
    OpJal   = 6'b000011,
    OpBeq   = 6'b000100,
    OpBne   = 6'b000101,
    OpAddi  = 6'b001000,
    OpAddiu = 6'b001001,
    OpSlti  = 6'b001010,
    OpSltiu = 6'b001011,
    OpAndi  = 6'b001100,
    OpOri   = 6'b001101,
    OpXori  = 6'b001110,
    OpLui   = 6'b001111,
    OpLw    = 6'b100011,
    OpSw    = 6'b101011,
    OpLl    = 6'b110000,
    OpSc    = 6'b111000,
    OpHalt  = 6'b111111
  } opcode_t;

  typedef enum logic [5:0] {
    FnSllv = 6'b000100,
    FnSrlv = 6'b000110,
    FnJr   = 6'b001000,
    FnAdd  = 6'b100000,
    FnAddu = 6'b100001,
    FnSub  = 6'b100010,
    FnSubu = 6'b100011,
    FnAnd  = 6'b100100,
    FnOr   = 6'b100101,
    FnXor  = 6'b100110,
    FnNor  = 6'b100111,
    FnSlt  = 6'b101010,
    FnSltu = 6'b101011
  } funct_t;

  typedef enum logic [3:0] {
    AluSll  = 4'b0000,
    AluSrl  = 4'b0001,
    AluAdd  = 4'b0010,
    AluSub  = 4'b0011,
    AluAnd  = 4'b0100,
    AluOr   = 4'b0101,
    AluXor  = 4'b0110,
    AluNor  = 4'b0111,
    AluSlt  = 4'b1010,
    AluSltu = 4'b1011
  } aluop_t;

  // PCSel encodings
  localparam logic [1:0] PcNext   = 2'b00;
  localparam logic [1:0] PcBranch = 2'b01;
  localparam logic [1:0] PcJump   = 2'b10;
  localparam logic [1:0] PcReg    = 2'b11;

  // wdataSrc encodings (memtoReg overrides for loads)
  localparam logic [1:0] WdAlu = 2'b00;
  localparam logic [1:0] WdPc4 = 2'b01;
  localparam logic [1:0] WdImm = 2'b10;

  typedef struct packed {
    logic     dREN;
    logic     dWEN;
    logic     halt;
    logic [1:0] PCSel;
    logic     branch;
    logic     branchSel;
    logic     memtoReg;
    logic     aluSrc;
    logic     datomic;
    aluop_t   ALUop;
    regbits_t rsel1;
    regbits_t rsel2;
    regbits_t wsel;
    word_t    immediate;
    logic     regWrite;
    logic [1:0] wdataSrc;
    opcode_t  opcode;
    funct_t   funct;
  } ctrl_t;

  function automatic word_t sext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

  function automatic word_t zext16(input logic [15:0] imm);
    return {16'h0000, imm};
  endfunction

endpackage

// File: rtl/mips_decoder.sv
// Purely combinational MIPS instruction decoder: one instruction word in, one control
// bundle out. Unknown opcodes and unknown R-type functs decode to an all-zero nop.
module mips_decoder
  import cpu_types_pkg::*;
(
  input  word_t instr_i,
  output ctrl_t ctrl_o
);

  opcode_t  op;
  funct_t   fn;
  regbits_t rs, rt, rd;
  logic [15:0] imm16;
  logic unused_shamt;

  assign op           = opcode_t'(instr_i[31:26]);
  assign fn           = funct_t'(instr_i[5:0]);
  assign rs           = instr_i[25:21];
  assign rt           = instr_i[20:16];
  assign rd           = instr_i[15:11];
  assign imm16        = instr_i[15:0];
  assign unused_shamt = ^instr_i[10:6];

  always_comb begin
    ctrl_o           = '0;
    ctrl_o.opcode    = op;
    ctrl_o.funct     = fn;
    ctrl_o.rsel1     = rs;
    ctrl_o.rsel2     = rt;
    ctrl_o.immediate = sext16(imm16);
    case (op)
      OpRtype: begin
        ctrl_o.regWrite = 1'b1;
        ctrl_o.wsel     = rd;
        case (fn)
          FnSllv:        ctrl_o.ALUop = AluSll;
          FnSrlv:        ctrl_o.ALUop = AluSrl;
          FnAdd, FnAddu: ctrl_o.ALUop = AluAdd;
          FnSub, FnSubu: ctrl_o.ALUop = AluSub;
          FnAnd:         ctrl_o.ALUop = AluAnd;
          FnOr:          ctrl_o.ALUop = AluOr;
          FnXor:         ctrl_o.ALUop = AluXor;
          FnNor:         ctrl_o.ALUop = AluNor;
          FnSlt:         ctrl_o.ALUop = AluSlt;
          FnSltu:        ctrl_o.ALUop = AluSltu;
          FnJr: begin
            ctrl_o.regWrite = 1'b0;
            ctrl_o.wsel     = '0;
            ctrl_o.PCSel    = PcReg;
          end
          default:       ctrl_o = '0;
        endcase
      end
      OpJ:   ctrl_o.PCSel = PcJump;
      OpJal: begin
        ctrl_o.PCSel    = PcJump;
        ctrl_o.regWrite = 1'b1;
        ctrl_o.wsel     = 5'd31;
        ctrl_o.wdataSrc = WdPc4;
      end
      OpBeq, OpBne: begin
        ctrl_o.PCSel     = PcBranch;
        ctrl_o.branch    = 1'b1;
        ctrl_o.branchSel = (op == OpBne);
        ctrl_o.ALUop     = AluSub;
      end
      OpAddi, OpAddiu, OpSlti, OpSltiu, OpAndi, OpOri, OpXori: begin
        ctrl_o.aluSrc   = 1'b1;
        ctrl_o.regWrite = 1'b1;
        ctrl_o.wsel     = rt;
        case (op)
          OpSlti:  ctrl_o.ALUop = AluSlt;
          OpSltiu: ctrl_o.ALUop = AluSltu;
          OpAndi:  ctrl_o.ALUop = AluAnd;
          OpOri:   ctrl_o.ALUop = AluOr;
          OpXori:  ctrl_o.ALUop = AluXor;
          default: ctrl_o.ALUop = AluAdd;
        endcase
        // Logical immediates zero-extend; arithmetic/compare sign-extend
        if (op == OpAndi || op == OpOri || op == OpXori) begin
          ctrl_o.immediate = zext16(imm16);
        end
      end
      OpLui: begin
        ctrl_o.regWrite  = 1'b1;
        ctrl_o.wsel      = rt;
        ctrl_o.wdataSrc  = WdImm;
        ctrl_o.immediate = {imm16, 16'h0000};
      end
      OpLw, OpLl: begin
        ctrl_o.dREN     = 1'b1;
        ctrl_o.memtoReg = 1'b1;
        ctrl_o.aluSrc   = 1'b1;
        ctrl_o.ALUop    = AluAdd;
        ctrl_o.regWrite = 1'b1;
        ctrl_o.wsel     = rt;
        ctrl_o.datomic  = (op == OpLl);
      end
      OpSw: begin
        ctrl_o.dWEN   = 1'b1;
        ctrl_o.aluSrc = 1'b1;
        ctrl_o.ALUop  = AluAdd;
      end
      OpSc: begin
        ctrl_o.dWEN     = 1'b1;
        ctrl_o.aluSrc   = 1'b1;
        ctrl_o.ALUop    = AluAdd;
        ctrl_o.datomic  = 1'b1;
        ctrl_o.regWrite = 1'b1;
        ctrl_o.wsel     = rt;
      end
      OpHalt:  ctrl_o.halt = 1'b1;
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/decode_queue.sv
// In-order queue of decoded instructions between fetch and register-read, with flush on
// redirect, enqueue blocking once a halt is queued, and a sticky halted flag.
module decode_queue
  import cpu_types_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PC_W  = 32
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  word_t                        in_instr,
  input  logic [PC_W-1:0]              in_pc,
  input  logic                         flush,
  output logic                         out_valid,
  input  logic                         out_ready,
  output ctrl_t                        out_ctrl,
  output logic [PC_W-1:0]              out_pc,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         halted
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

  ctrl_t dec_ctrl;

  mips_decoder u_decoder (
    .instr_i (in_instr),
    .ctrl_o  (dec_ctrl)
  );

  ctrl_t           ctrl_mem_q [DEPTH];
  logic [PC_W-1:0] pc_mem_q   [DEPTH];

  logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;
  logic            halt_seen_q, halt_seen_d;
  logic            halted_q, halted_d;
  logic            enq, deq, wr_en;

  assign in_ready  = (count_q != FullCnt) && !halt_seen_q && !halted_q;
  assign out_valid = (count_q != '0);
  assign enq       = in_valid && in_ready;
  assign deq       = out_valid && out_ready;
  assign wr_en     = enq && !flush;
  assign out_ctrl  = out_valid ? ctrl_mem_q[head_q] : '0;
  assign out_pc    = out_valid ? pc_mem_q[head_q] : '0;
  assign count     = count_q;
  assign halted    = halted_q;

  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    halt_seen_d = halt_seen_q;
    halted_d    = halted_q;
    if (flush) begin
      head_d      = '0;
      tail_d      = '0;
      count_d     = '0;
      halt_seen_d = 1'b0;
    end else begin
      if (enq) begin
        tail_d = tail_q + PtrW'(1);
        if (dec_ctrl.halt) halt_seen_d = 1'b1;
      end
      if (deq) begin
        head_d = head_q + PtrW'(1);
        if (ctrl_mem_q[head_q].halt) halted_d = 1'b1;
      end
      case ({enq, deq})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      halt_seen_q <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      halt_seen_q <= halt_seen_d;
      halted_q    <= halted_d;
    end
  end

  // Payload storage needs no reset: outputs are masked while the queue is empty
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      ctrl_mem_q[tail_q] <= dec_ctrl;
      pc_mem_q[tail_q]   <= in_pc;
    end
  end

endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue (DEPTH=4): decode fields, ordering, full/empty edges,
// flush precedence and halt handling, with hand-computed expectations.
module tb_decode_queue;
  import cpu_types_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned PC_W  = 32;

  localparam word_t I_ADDU = 32'h0022_1821;  // addu $3,$1,$2
  localparam word_t I_ORI  = 32'h3405_FFFF;  // ori  $5,$0,0xffff
  localparam word_t I_ADDI = 32'h2005_FFFF;  // addi $5,$0,0xffff
  localparam word_t I_LUI  = 32'h3C05_1234;  // lui  $5,0x1234
  localparam word_t I_LL   = 32'hC044_0000;  // ll   $4,0($2)
  localparam word_t I_SC   = 32'hE044_0000;  // sc   $4,0($2)
  localparam word_t I_UNDF = 32'h0400_0000;  // opcode 000001, not decoded
  localparam word_t I_HALT = 32'hFFFF_FFFF;

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  word_t           in_instr = '0;
  logic [PC_W-1:0] in_pc = '0;
  logic            flush = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  ctrl_t           out_ctrl;
  logic [PC_W-1:0] out_pc;
  logic [2:0]      count;
  logic            halted;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  decode_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_pc    (out_pc),
    .count     (count),
    .halted    (halted)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, step past the rising edge, then idle the inputs.
  task automatic cycle(input logic iv, input word_t ins, input logic [31:0] pc,
                       input logic ordy, input logic fl);
    in_valid  = iv;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    @(posedge CLK);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
  endtask

  initial begin
    // Reset state
    #12;
    check_eq("rst count", 32'(count), 32'd0);
    check_eq("rst out_valid", 32'(out_valid), 32'd0);
    check_eq("rst out_ctrl", 32'(out_ctrl.ALUop) | out_ctrl.immediate, 32'd0);
    check_eq("rst out_pc", out_pc, 32'd0);
    check_eq("rst in_ready", 32'(in_ready), 32'd1);
    check_eq("rst halted", 32'(halted), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    #1;

    // ADDU from empty: visible only after the accepting edge
    in_valid = 1'b1;
    in_instr = I_ADDU;
    in_pc    = 32'h0;
    #1;
    check_eq("addu no bypass", 32'(out_valid), 32'd0);
    cycle(1'b1, I_ADDU, 32'h0, 1'b0, 1'b0);
    check_eq("addu out_valid", 32'(out_valid), 32'd1);
    check_eq("addu aluop", 32'(out_ctrl.ALUop), 32'(AluAdd));
    check_eq("addu rsel1", 32'(out_ctrl.rsel1), 32'd1);
    check_eq("addu rsel2", 32'(out_ctrl.rsel2), 32'd2);
    check_eq("addu wsel", 32'(out_ctrl.wsel), 32'd3);
    check_eq("addu regwrite", 32'(out_ctrl.regWrite), 32'd1);
    check_eq("addu count", 32'(count), 32'd1);
    cycle(1'b0, '0, 32'h0, 1'b1, 1'b0);
    check_eq("addu drained", 32'(count), 32'd0);

    // Fill to DEPTH, then dequeue with in_valid held
    for (int i = 0; i < 4; i++) cycle(1'b1, I_ADDU, 32'(4 + 4 * i), 1'b0, 1'b0);
    check_eq("full count", 32'(count), 32'd4);
    check_eq("full in_ready", 32'(in_ready), 32'd0);
    check_eq("full head pc", out_pc, 32'h4);
    cycle(1'b1, I_ADDU, 32'h14, 1'b1, 1'b0);
    check_eq("full deq count", 32'(count), 32'd3);
    check_eq("full deq in_ready", 32'(in_ready), 32'd1);
    check_eq("full deq pc", out_pc, 32'h8);
    cycle(1'b1, I_ADDU, 32'h14, 1'b1, 1'b0);
    check_eq("enq+deq count", 32'(count), 32'd3);
    check_eq("enq+deq pc", out_pc, 32'hC);
    cycle(1'b0, '0, 32'h0, 1'b1, 1'b0);
    check_eq("drain1 pc", out_pc, 32'h10);
    cycle(1'b0, '0, 32'h0, 1'b1, 1'b0);
    check_eq("drain2 pc (wrapped)", out_pc, 32'h14);
    cycle(1'b0, '0, 32'h0, 1'b1, 1'b0);
    check_eq("drain3 count", 32'(count), 32'd0);
    check_eq("drain3 out_pc zero", out_pc, 32'h0);

    // Immediates; first one also exercises enq+deq on an empty queue
    cycle(1'b1, I_ORI, 32'h100, 1'b1, 1'b0);
    check_eq("empty enq+deq count", 32'(count), 32'd1);
    check_eq("ori imm", out_ctrl.immediate, 32'h0000_FFFF);
    check_eq("ori aluop", 32'(out_ctrl.ALUop), 32'(AluOr));
    check_eq("ori wsel", 32'(out_ctrl.wsel), 32'd5);
    cycle(1'b1, I_ADDI, 32'h104, 1'b1, 1'b0);
    check_eq("addi imm", out_ctrl.immediate, 32'hFFFF_FFFF);
    check_eq("addi pc", out_pc, 32'h104);
    cycle(1'b1, I_LUI, 32'h108, 1'b1, 1'b0);
    check_eq("lui imm", out_ctrl.immediate, 32'h1234_0000);
    cycle(1'b0, '0, 32'h0, 1'b1, 1'b0);
    check_eq("imm drained", 32'(count), 32'd0);

    // LL / SC
    cycle(1'b1, I_LL, 32'h200, 1'b0, 1'b0);
    cycle(1'b1, I_SC, 32'h204, 1'b0, 1'b0);
    check_eq("ll count", 32'(count), 32'd2);
    check_eq("ll datomic", 32'(out_ctrl.datomic), 32'd1);
    check_eq("ll dren", 32'(out_ctrl.dREN), 32'd1);
    check_eq("ll memtoreg", 32'(out_ctrl.memtoReg), 32'd1);
    check_eq("ll wsel", 32'(out_ctrl.wsel), 32'd4);
    cycle(1'b0, '0, 32'h0, 1'b1, 1'b0);
    check_eq("sc datomic", 32'(out_ctrl.datomic), 32'd1);
    check_eq("sc dwen", 32'(out_ctrl.dWEN), 32'd1);
    check_eq("sc dren", 32'(out_ctrl.dREN), 32'd0);
    check_eq("sc regwrite", 32'(out_ctrl.regWrite), 32'd1);
    check_eq("sc wsel", 32'(out_ctrl.wsel), 32'd4);
    cycle(1'b0, '0, 32'h0, 1'b1, 1'b0);

    // Undefined opcode decodes to all-zero controls
    cycle(1'b1, I_UNDF, 32'h280, 1'b0, 1'b0);
    check_eq("undef valid", 32'(out_valid), 32'd1);
    check_eq("undef ctrl low", out_ctrl[31:0], 32'h0);
    check_eq("undef ctrl high", 32'(out_ctrl[75:32]), 32'h0);
    check_eq("undef ctrl top", 32'(out_ctrl[75:64]), 32'h0);
    cycle(1'b0, '0, 32'h0, 1'b1, 1'b0);

    // Flush beats simultaneous enqueue and dequeue, clears halt_seen
    cycle(1'b1, I_ADDU, 32'h300, 1'b0, 1'b0);
    cycle(1'b1, I_ADDU, 32'h304, 1'b0, 1'b0);
    cycle(1'b1, I_HALT, 32'h308, 1'b0, 1'b0);
    check_eq("pre-flush count", 32'(count), 32'd3);
    check_eq("pre-flush in_ready", 32'(in_ready), 32'd0);
    cycle(1'b1, I_ADDU, 32'h30C, 1'b1, 1'b1);
    check_eq("flush count", 32'(count), 32'd0);
    check_eq("flush out_valid", 32'(out_valid), 32'd0);
    check_eq("flush in_ready", 32'(in_ready), 32'd1);
    check_eq("flush halted", 32'(halted), 32'd0);
    cycle(1'b1, I_ADDU, 32'h400, 1'b0, 1'b0);
    check_eq("post-flush count", 32'(count), 32'd1);
    check_eq("post-flush pc", out_pc, 32'h400);
    cycle(1'b0, '0, 32'h0, 1'b1, 1'b0);

    // Halt blocks enqueue; dequeue of halt sets sticky halted
    cycle(1'b1, I_HALT, 32'h500, 1'b0, 1'b0);
    check_eq("halt in_ready", 32'(in_ready), 32'd0);
    check_eq("halt ctrl", 32'(out_ctrl.halt), 32'd1);
    cycle(1'b1, I_ADDU, 32'h504, 1'b0, 1'b0);
    check_eq("halt blocks enq", 32'(count), 32'd1);
    check_eq("halted before deq", 32'(halted), 32'd0);
    cycle(1'b0, '0, 32'h0, 1'b1, 1'b0);
    check_eq("halted after deq", 32'(halted), 32'd1);
    check_eq("halted count", 32'(count), 32'd0);
    check_eq("halted in_ready", 32'(in_ready), 32'd0);
    cycle(1'b0, '0, 32'h0, 1'b0, 1'b1);
    check_eq("halted survives flush", 32'(halted), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
